sdram_fb_arbiter: RTL and testbench

//  Shares the single SDRAM/PSRAM controller command port between two framebuffer requesters.
//  The camera writer drains FIFO_cam and issues bursts. The LCD reader refills the LCD_Controller line queue.

---
 rtl/fb_arb_pkg.sv | 15 +
 rtl/fb_arb_priority.sv | 38 +++
 rtl/sdram_fb_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_sdram_fb_arbiter.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_arb_pkg.sv
// fb_arb_pkg: state encoding and command codes shared by the framebuffer arbiter.
package fb_arb_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_BURST = 3'd1,
        RD_CMD   = 3'd2,
        RD_DATA  = 3'd3,
        RECOVER  = 3'd4
    } fb_arb_state_t;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

endpackage

// File: rtl/fb_arb_priority.sv
// fb_arb_priority: read-first grant decision with a starvation guard that forces a
// write grant after MAX_RD_RUN consecutive reads while the writer is waiting.
module fb_arb_priority #(
    parameter int MAX_RD_RUN = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic idle,
    input  logic arb_en,
    input  logic rd_req,
    input  logic wr_req,
    output logic grant_rd,
    output logic grant_wr
);

    localparam int RUN_W = $clog2(MAX_RD_RUN + 1);

    logic [RUN_W-1:0] rd_run;
    logic             guard;

    assign guard    = wr_req && (rd_run == RUN_W'(MAX_RD_RUN));
    assign grant_rd = idle && arb_en && rd_req && !guard;
    assign grant_wr = idle && arb_en && wr_req && !grant_rd;

    // The run only means something while a write is pending, so an absent writer clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_run <= '0;
        end else if (idle) begin
            if (grant_wr || !wr_req) begin
                rd_run <= '0;
            end else if (grant_rd && (rd_run != RUN_W'(MAX_RD_RUN))) begin
                rd_run <= rd_run + RUN_W'(1);
            end
        end
    end

endmodule

// File: rtl/sdram_fb_arbiter.sv
// sdram_fb_arbiter: shares one memory controller command port between the camera
// writer and the LCD reader, turning burst requests into command/data transactions.
module sdram_fb_arbiter
    import fb_arb_pkg::*;
#(
    parameter int ADDR_W     = 21,
    parameter int DATA_W     = 32,
    parameter int BURST_LEN  = 8,
    parameter int MAX_RD_RUN = 4,
    parameter int WR_RECOVER = 3,
    parameter int RD_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              mem_init_done,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_data_rd_en,
    output logic              wr_ack,
    output logic              wr_done,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_valid,
    output logic              rd_done,
    output logic              rd_error,
    output logic              mem_cmd,
    output logic              mem_cmd_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_w_data,
    input  logic [DATA_W-1:0] mem_r_data,
    input  logic              mem_r_data_valid,
    output logic              busy
);

    localparam int CNT_MAX = (BURST_LEN > WR_RECOVER) ? BURST_LEN : WR_RECOVER;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int TMO_W   = $clog2(RD_TIMEOUT + 1);

    fb_arb_state_t     state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [TMO_W-1:0]  tmo, tmo_nxt;
    logic              wr_ack_nxt, wr_done_nxt, rd_ack_nxt, rd_done_nxt, rd_error_nxt;
    logic              mem_cmd_nxt, mem_cmd_en_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic              arb_idle, grant_rd, grant_wr, beat;

    assign arb_idle      = (state == IDLE);
    assign busy          = (state != IDLE);
    assign wr_data_rd_en = (state == WR_BURST);
    assign beat          = (state == RD_DATA) && mem_r_data_valid;

    fb_arb_priority #(
        .MAX_RD_RUN(MAX_RD_RUN)
    ) u_priority (
        .clk      (clk),
        .reset_n  (reset_n),
        .idle     (arb_idle),
        .arb_en   (mem_init_done),
        .rd_req   (rd_req),
        .wr_req   (wr_req),
        .grant_rd (grant_rd),
        .grant_wr (grant_wr)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            tmo        <= '0;
            wr_ack     <= 1'b0;
            wr_done    <= 1'b0;
            rd_ack     <= 1'b0;
            rd_done    <= 1'b0;
            rd_error   <= 1'b0;
            mem_cmd    <= 1'b0;
            mem_cmd_en <= 1'b0;
            mem_addr   <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            tmo        <= tmo_nxt;
            wr_ack     <= wr_ack_nxt;
            wr_done    <= wr_done_nxt;
            rd_ack     <= rd_ack_nxt;
            rd_done    <= rd_done_nxt;
            rd_error   <= rd_error_nxt;
            mem_cmd    <= mem_cmd_nxt;
            mem_cmd_en <= mem_cmd_en_nxt;
            mem_addr   <= mem_addr_nxt;
        end
    end

    // Control outputs are registered, so every pulse shows up in the first cycle of the new state.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        tmo_nxt        = tmo;
        wr_ack_nxt     = 1'b0;
        wr_done_nxt    = 1'b0;
        rd_ack_nxt     = 1'b0;
        rd_done_nxt    = 1'b0;
        rd_error_nxt   = 1'b0;
        mem_cmd_en_nxt = 1'b0;
        mem_cmd_nxt    = mem_cmd;
        mem_addr_nxt   = mem_addr;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                tmo_nxt = '0;
                if (grant_rd) begin
                    state_nxt      = RD_CMD;
                    rd_ack_nxt     = 1'b1;
                    mem_cmd_en_nxt = 1'b1;
                    mem_cmd_nxt    = CMD_READ;
                    mem_addr_nxt   = rd_addr;
                end else if (grant_wr) begin
                    state_nxt      = WR_BURST;
                    wr_ack_nxt     = 1'b1;
                    mem_cmd_en_nxt = 1'b1;
                    mem_cmd_nxt    = CMD_WRITE;
                    mem_addr_nxt   = wr_addr;
                end
            end
            WR_BURST: begin
                if (cnt == CNT_W'(BURST_LEN - 1)) begin
                    state_nxt   = RECOVER;
                    cnt_nxt     = '0;
                    wr_done_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            RECOVER: begin
                if (cnt == CNT_W'(WR_RECOVER - 1)) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            RD_CMD: begin
                state_nxt = RD_DATA;
            end
            RD_DATA: begin
                if (beat) begin
                    tmo_nxt = '0;
                    if (cnt == CNT_W'(BURST_LEN - 1)) begin
                        state_nxt   = IDLE;
                        rd_done_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end else if (tmo == TMO_W'(RD_TIMEOUT - 1)) begin
                    state_nxt    = IDLE;
                    rd_done_nxt  = 1'b1;
                    rd_error_nxt = 1'b1;
                end else begin
                    tmo_nxt = tmo + TMO_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Data path: one register stage between the pop/beat and the outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_w_data    <= '0;
            rd_data       <= '0;
            rd_data_valid <= 1'b0;
        end else begin
            rd_data_valid <= beat;
            if (wr_data_rd_en) begin
                mem_w_data <= wr_data;
            end
            if (beat) begin
                rd_data <= mem_r_data;
            end
        end
    end

endmodule

// File: tb/tb_sdram_fb_arbiter.sv
// tb_sdram_fb_arbiter: scenario tasks with a FIFO/controller model and a grant-order
// model built from the arbitration rules.
module tb_sdram_fb_arbiter;

    localparam int ADDR_W     = 21;
    localparam int DATA_W     = 32;
    localparam int BURST_LEN  = 8;
    localparam int MAX_RD_RUN = 4;
    localparam int WR_RECOVER = 3;
    localparam int RD_TIMEOUT = 64;
    localparam int OW         = 10 + 2 * DATA_W + ADDR_W;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              mem_init_done = 1'b0;
    logic              wr_req = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              wr_data_rd_en, wr_ack, wr_done;
    logic              rd_req = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic              rd_ack, rd_data_valid, rd_done, rd_error;
    logic [DATA_W-1:0] rd_data;
    logic              mem_cmd, mem_cmd_en, busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_w_data;
    logic [DATA_W-1:0] mem_r_data = '0;
    logic              mem_r_data_valid = 1'b0;
    logic [OW-1:0]     outs;

    always #5 clk = ~clk;

    sdram_fb_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN),
        .MAX_RD_RUN(MAX_RD_RUN), .WR_RECOVER(WR_RECOVER), .RD_TIMEOUT(RD_TIMEOUT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .mem_init_done(mem_init_done),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_data_rd_en(wr_data_rd_en), .wr_ack(wr_ack), .wr_done(wr_done),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
        .rd_data_valid(rd_data_valid), .rd_done(rd_done), .rd_error(rd_error),
        .mem_cmd(mem_cmd), .mem_cmd_en(mem_cmd_en), .mem_addr(mem_addr),
        .mem_w_data(mem_w_data), .mem_r_data(mem_r_data),
        .mem_r_data_valid(mem_r_data_valid), .busy(busy)
    );

    assign outs = {wr_data_rd_en, wr_ack, wr_done, rd_ack, rd_data, rd_data_valid,
                   rd_done, rd_error, mem_cmd, mem_cmd_en, mem_addr, mem_w_data, busy};

    int n_vec = 0, n_fail = 0, cyc = 0;
    logic [DATA_W-1:0] wbuf [256];
    int  wi = 0;
    bit  pop_pend = 1'b0;
    int  resp_wait = 0, resp_left = 0, resp_beats = BURST_LEN, resp_idx = 0;
    bit  resp_fixed = 1'b0;
    int  last_beat_cyc = 0, rd_done_cyc = 0, wr_done_cyc = 0;
    int  n_wr_done = 0, n_rd_done = 0;
    bit  last_rd_err = 1'b0;
    bit  grant_q[$];
    int  grant_cyc_q[$];
    logic [ADDR_W:0]   cmd_q[$];
    logic [DATA_W-1:0] obs_rd[$], sent_rd[$], obs_wr[$];
    int  obs_rd_cyc[$], sent_rd_cyc[$];

    // One clock: writer FIFO model, event recording, and read-beat responder.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (pop_pend) begin
            obs_wr.push_back(mem_w_data);
            wi++;
        end
        wr_data  = wbuf[wi % 256];
        pop_pend = wr_data_rd_en;
        if (wr_ack) begin grant_q.push_back(1'b1); grant_cyc_q.push_back(cyc); end
        if (rd_ack) begin grant_q.push_back(1'b0); grant_cyc_q.push_back(cyc); end
        if (mem_cmd_en) begin
            cmd_q.push_back({mem_cmd, mem_addr});
            if (mem_cmd == 1'b0) begin
                resp_wait = 1 + $urandom_range(0, 2);
                resp_left = resp_beats;
                resp_idx  = 0;
            end
        end
        if (wr_done) begin n_wr_done++; wr_done_cyc = cyc; end
        if (rd_done) begin n_rd_done++; rd_done_cyc = cyc; last_rd_err = rd_error; end
        if (rd_data_valid) begin obs_rd.push_back(rd_data); obs_rd_cyc.push_back(cyc); end
        mem_r_data_valid = 1'b0;
        if (resp_left > 0) begin
            if (resp_wait > 0) begin
                resp_wait--;
            end else if ($urandom_range(0, 3) != 0) begin
                mem_r_data_valid = 1'b1;
                mem_r_data = resp_fixed ? DATA_W'(32'hA0 + resp_idx) : DATA_W'($urandom);
                sent_rd.push_back(mem_r_data);
                sent_rd_cyc.push_back(cyc);
                last_beat_cyc = cyc;
                resp_idx++;
                resp_left--;
            end
        end
    endtask

    task automatic settle();
        for (int i = 0; i < 400 && (busy || resp_left > 0); i++) step();
        step();
        step();
    endtask

    task automatic clear_obs();
        grant_q.delete(); grant_cyc_q.delete(); cmd_q.delete();
        obs_rd.delete(); sent_rd.delete(); obs_wr.delete();
        obs_rd_cyc.delete(); sent_rd_cyc.delete();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        n_vec++;
        if (outs !== '0) begin n_fail++; $display("FAIL reset_outputs: got %0h, expected 0", outs); end
        reset_n = 1'b1;
        mem_init_done = 1'b1;
        step();
        step();
        n_vec++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle: busy got %0b, expected 0", busy); end
    endtask

    task automatic test_write_single();
        int s, nd, got;
        clear_obs();
        for (int k = 0; k < BURST_LEN; k++) wbuf[(wi + k) % 256] = DATA_W'(k + 1);
        wr_data = wbuf[wi % 256];
        wr_addr = ADDR_W'(32'h00100);
        wr_req  = 1'b1;
        s = cyc;
        for (int i = 0; i < 50 && grant_q.size() == 0; i++) step();
        wr_req = 1'b0;
        got = (grant_q.size() > 0) ? grant_cyc_q[0] : -1;
        n_vec++;
        if (got !== s + 1) begin n_fail++; $display("FAIL wr_ack_cycle: got %0d, expected %0d", got, s + 1); end
        nd = n_wr_done;
        for (int i = 0; i < 50 && n_wr_done == nd; i++) step();
        n_vec++;
        if (wr_done_cyc !== got + BURST_LEN) begin
            n_fail++; $display("FAIL wr_done_cycle: got %0d, expected %0d", wr_done_cyc, got + BURST_LEN);
        end
        n_vec++;
        if (cmd_q.size() !== 1 || cmd_q[0] !== {1'b1, ADDR_W'(32'h00100)}) begin
            n_fail++; $display("FAIL wr_cmd: got %0d cmds first %0h, expected 1 cmd %0h",
                               cmd_q.size(), (cmd_q.size() > 0) ? cmd_q[0] : '0, {1'b1, ADDR_W'(32'h00100)});
        end
        n_vec++;
        if (obs_wr.size() !== BURST_LEN) begin
            n_fail++; $display("FAIL wr_beats: got %0d, expected %0d", obs_wr.size(), BURST_LEN);
        end
        for (int k = 0; k < BURST_LEN && k < obs_wr.size(); k++) begin
            n_vec++;
            if (obs_wr[k] !== DATA_W'(k + 1)) begin
                n_fail++; $display("FAIL wr_data[%0d]: got %0h, expected %0h", k, obs_wr[k], k + 1);
            end
        end
        for (int i = 0; i < WR_RECOVER - 1; i++) step();
        n_vec++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL wr_recover_busy: got %0b, expected 1", busy); end
        step();
        n_vec++;
        if (busy !== 1'b0 || cmd_q.size() !== 1) begin
            n_fail++; $display("FAIL wr_recover_end: busy %0b cmds %0d, expected busy 0 cmds 1", busy, cmd_q.size());
        end
        settle();
    endtask

    task automatic test_back_to_back();
        int w0, nd, gap;
        clear_obs();
        wr_addr = ADDR_W'($urandom);
        wr_req  = 1'b1;
        for (int i = 0; i < 50 && grant_q.size() < 1; i++) step();
        w0 = wi;
        for (int i = 0; i < 100 && grant_q.size() < 2; i++) step();
        wr_req = 1'b0;
        nd = n_wr_done;
        for (int i = 0; i < 100 && obs_wr.size() < 2 * BURST_LEN; i++) step();
        settle();
        gap = (grant_q.size() >= 2) ? grant_cyc_q[1] - grant_cyc_q[0] : -1;
        n_vec++;
        if (gap !== BURST_LEN + WR_RECOVER + 1) begin
            n_fail++; $display("FAIL b2b_gap: got %0d, expected %0d", gap, BURST_LEN + WR_RECOVER + 1);
        end
        n_vec++;
        if (obs_wr.size() !== 2 * BURST_LEN) begin
            n_fail++; $display("FAIL b2b_beats: got %0d, expected %0d", obs_wr.size(), 2 * BURST_LEN);
        end
        for (int k = 0; k < obs_wr.size() && k < 2 * BURST_LEN; k++) begin
            n_vec++;
            if (obs_wr[k] !== wbuf[(w0 + k) % 256]) begin
                n_fail++; $display("FAIL b2b_data[%0d]: got %0h, expected %0h", k, obs_wr[k], wbuf[(w0 + k) % 256]);
            end
        end
        n_vec++;
        if (n_wr_done - nd !== 1 && n_wr_done - nd !== 2) begin
            n_fail++; $display("FAIL b2b_done: got %0d, expected 2", n_wr_done - nd);
        end
    endtask

    task automatic test_read();
        int s, nd, got;
        clear_obs();
        resp_fixed = 1'b1;
        resp_beats = BURST_LEN;
        rd_addr = ADDR_W'(32'h00200);
        rd_req  = 1'b1;
        s = cyc;
        for (int i = 0; i < 50 && grant_q.size() == 0; i++) step();
        rd_req = 1'b0;
        got = (grant_q.size() > 0) ? grant_cyc_q[0] : -1;
        n_vec++;
        if (got !== s + 1 || grant_q[0] !== 1'b0) begin
            n_fail++; $display("FAIL rd_ack: cycle %0d, expected read at %0d", got, s + 1);
        end
        n_vec++;
        if (cmd_q.size() < 1 || cmd_q[0] !== {1'b0, ADDR_W'(32'h00200)}) begin
            n_fail++; $display("FAIL rd_cmd: got %0h, expected %0h", (cmd_q.size() > 0) ? cmd_q[0] : '0, {1'b0, ADDR_W'(32'h00200)});
        end
        nd = n_rd_done;
        for (int i = 0; i < 200 && n_rd_done == nd; i++) step();
        n_vec++;
        if (n_rd_done !== nd + 1 || last_rd_err !== 1'b0) begin
            n_fail++; $display("FAIL rd_done: got %0d err %0b, expected 1 err 0", n_rd_done - nd, last_rd_err);
        end
        n_vec++;
        if (obs_rd.size() !== BURST_LEN) begin
            n_fail++; $display("FAIL rd_beats: got %0d, expected %0d", obs_rd.size(), BURST_LEN);
        end
        for (int k = 0; k < obs_rd.size() && k < sent_rd_cyc.size(); k++) begin
            n_vec++;
            if (obs_rd[k] !== DATA_W'(32'hA0 + k) || obs_rd_cyc[k] - sent_rd_cyc[k] !== 1) begin
                n_fail++; $display("FAIL rd_data[%0d]: got %0h lag %0d, expected %0h lag 1",
                                   k, obs_rd[k], obs_rd_cyc[k] - sent_rd_cyc[k], 32'hA0 + k);
            end
        end
        n_vec++;
        if (obs_rd.size() > 0 && rd_done_cyc !== obs_rd_cyc[obs_rd.size() - 1]) begin
            n_fail++; $display("FAIL rd_done_align: got %0d, expected %0d", rd_done_cyc, obs_rd_cyc[obs_rd.size() - 1]);
        end
        resp_fixed = 1'b0;
        settle();
    endtask

    task automatic test_timeout();
        int nd, s, got;
        clear_obs();
        resp_beats = 5;
        rd_addr = ADDR_W'($urandom);
        rd_req  = 1'b1;
        for (int i = 0; i < 50 && grant_q.size() == 0; i++) step();
        rd_req = 1'b0;
        nd = n_rd_done;
        for (int i = 0; i < 300 && n_rd_done == nd; i++) step();
        resp_beats = BURST_LEN;
        n_vec++;
        if (last_rd_err !== 1'b1 || rd_done_cyc !== last_beat_cyc + RD_TIMEOUT + 1) begin
            n_fail++; $display("FAIL rd_timeout: done at %0d err %0b, expected %0d err 1",
                               rd_done_cyc, last_rd_err, last_beat_cyc + RD_TIMEOUT + 1);
        end
        n_vec++;
        if (obs_rd.size() !== 5) begin n_fail++; $display("FAIL rd_timeout_beats: got %0d, expected 5", obs_rd.size()); end
        for (int k = 0; k < obs_rd.size() && k < sent_rd.size(); k++) begin
            n_vec++;
            if (obs_rd[k] !== sent_rd[k]) begin
                n_fail++; $display("FAIL rd_timeout_data[%0d]: got %0h, expected %0h", k, obs_rd[k], sent_rd[k]);
            end
        end
        wr_addr = ADDR_W'($urandom);
        wr_req  = 1'b1;
        s = cyc;
        step();
        wr_req = 1'b0;
        got = (grant_q.size() > 1) ? grant_cyc_q[1] : -1;
        n_vec++;
        if (got !== s + 1) begin n_fail++; $display("FAIL post_timeout_grant: got %0d, expected %0d", got, s + 1); end
        settle();
    endtask

    task automatic test_stray_beat();
        clear_obs();
        mem_r_data       = DATA_W'($urandom);
        mem_r_data_valid = 1'b1;
        step();
        step();
        n_vec++;
        if (obs_rd.size() !== 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL stray_beat: got %0d beats busy %0b, expected 0 beats busy 0", obs_rd.size(), busy);
        end
    endtask

    task automatic test_grant_order();
        int  run;
        bit  exp_w;
        clear_obs();
        rd_addr = ADDR_W'($urandom);
        wr_addr = ADDR_W'($urandom);
        rd_req  = 1'b1;
        wr_req  = 1'b1;
        for (int i = 0; i < 3000 && grant_q.size() < 10; i++) step();
        rd_req = 1'b0;
        wr_req = 1'b0;
        settle();
        n_vec++;
        if (grant_q.size() !== 10) begin n_fail++; $display("FAIL order_count: got %0d, expected 10", grant_q.size()); end
        run = 0;
        for (int k = 0; k < grant_q.size() && k < 10; k++) begin
            exp_w = (run >= MAX_RD_RUN);
            if (exp_w) run = 0;
            else run++;
            n_vec++;
            if (grant_q[k] !== exp_w) begin
                n_fail++; $display("FAIL order[%0d]: got %s, expected %s", k, grant_q[k] ? "W" : "R", exp_w ? "W" : "R");
            end
        end
        n_vec++;
        if (obs_rd.size() !== sent_rd.size()) begin
            n_fail++; $display("FAIL order_rd_beats: got %0d, expected %0d", obs_rd.size(), sent_rd.size());
        end
        for (int k = 0; k < obs_rd.size() && k < sent_rd.size(); k++) begin
            n_vec++;
            if (obs_rd[k] !== sent_rd[k]) begin
                n_fail++; $display("FAIL order_rd_data[%0d]: got %0h, expected %0h", k, obs_rd[k], sent_rd[k]);
            end
        end
    endtask

    task automatic test_init_gate();
        int s, got;
        clear_obs();
        mem_init_done = 1'b0;
        rd_req = 1'b1;
        wr_req = 1'b1;
        for (int i = 0; i < 20; i++) step();
        n_vec++;
        if (grant_q.size() !== 0 || cmd_q.size() !== 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL init_gate: got %0d grants %0d cmds, expected 0 and 0", grant_q.size(), cmd_q.size());
        end
        mem_init_done = 1'b1;
        s = cyc;
        step();
        rd_req = 1'b0;
        wr_req = 1'b0;
        got = (grant_q.size() > 0) ? grant_cyc_q[0] : -1;
        n_vec++;
        if (got !== s + 1 || grant_q[0] !== 1'b0) begin
            n_fail++; $display("FAIL init_first_grant: got cycle %0d, expected read at %0d", got, s + 1);
        end
        settle();
    endtask

    task automatic test_init_drop();
        int nd;
        clear_obs();
        wr_addr = ADDR_W'($urandom);
        wr_req  = 1'b1;
        for (int i = 0; i < 50 && grant_q.size() == 0; i++) step();
        mem_init_done = 1'b0;
        nd = n_wr_done;
        for (int i = 0; i < 40; i++) step();
        n_vec++;
        if (n_wr_done !== nd + 1 || grant_q.size() !== 1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL init_drop: got %0d done %0d grants, expected 1 done 1 grant", n_wr_done - nd, grant_q.size());
        end
        mem_init_done = 1'b1;
        for (int i = 0; i < 10 && grant_q.size() < 2; i++) step();
        wr_req = 1'b0;
        n_vec++;
        if (grant_q.size() !== 2) begin n_fail++; $display("FAIL init_resume: got %0d grants, expected 2", grant_q.size()); end
        settle();
    endtask

    task automatic test_reset_mid_write();
        int nd, nc;
        clear_obs();
        wr_addr = ADDR_W'($urandom);
        wr_req  = 1'b1;
        for (int i = 0; i < 50 && grant_q.size() == 0; i++) step();
        wr_req = 1'b0;
        for (int i = 0; i < 3; i++) step();
        nd = n_wr_done;
        reset_n = 1'b0;
        #1;
        n_vec++;
        if (outs !== '0) begin n_fail++; $display("FAIL reset_mid_write: got %0h, expected 0", outs); end
        step();
        step();
        reset_n = 1'b1;
        nc = cmd_q.size();
        for (int i = 0; i < 20; i++) step();
        n_vec++;
        if (n_wr_done !== nd || busy !== 1'b0 || cmd_q.size() !== nc) begin
            n_fail++; $display("FAIL reset_no_done: got %0d done busy %0b, expected 0 done busy 0", n_wr_done - nd, busy);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) wbuf[i] = DATA_W'($urandom);
        test_reset();
        test_write_single();
        test_back_to_back();
        test_read();
        test_timeout();
        test_stray_beat();
        test_grant_order();
        test_init_gate();
        test_init_drop();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
